k052109_addr_sel_slice: RTL and testbench



---
 rtl/k052109_pkg.sv | 17 +
 rtl/k052109_sel_bit.sv | 65 ++++++
 rtl/k052109_addr_sel_slice.sv | 61 ++++++
 tb/tb_k052109_addr_sel_slice.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/k052109_pkg.sv
// Shared constants for the 052109 address-select slice.
// Optional build macro: K052109_CELL_DELAY_EN. When it is defined, the
// cell-path delay constants below are applied as simulation-only delays.
`timescale 1ns/1ps
package k052109_pkg;

  // Default number of address bits handled side by side.
  localparam int unsigned K052109_WIDTH = 32'd8;

  // Propagation delays of the die cells, in ns. They are only used when
  // K052109_CELL_DELAY_EN is defined.
  localparam realtime T5A_DLY_NS  = 1.0;   // T5A selector, output Xn
  localparam realtime INV1_DLY_NS = 0.55;  // inverter after T5A (ab)
  localparam realtime D24_DLY_NS  = 0.8;   // D24 AOI22, output X
  localparam realtime INV2_DLY_NS = 0.64;  // inverter after D24 (ra)

endpackage : k052109_pkg

// File: rtl/k052109_sel_bit.sv
// One bit of the 052109 address select: a T5A 4:1 inverting selector, an
// inverter, a D24 AOI22 override stage and a final inverter. The select
// pairs are taken as independent wires, exactly as on the die, so the
// logic stays correct even when a pair is not complementary.
// Optional build macro: K052109_CELL_DELAY_EN adds simulation delays.
`timescale 1ns/1ps
module k052109_sel_bit
  import k052109_pkg::*;
(
  input  logic a1,
  input  logic a2,
  input  logic b1,
  input  logic b2,
  input  logic c,
  input  logic sela,
  input  logic sela_n,
  input  logic selb,
  input  logic selb_n,
  input  logic selc,
  input  logic selc_n,
  output logic ra
);

  logic ga_s;
  logic gb_s;
  logic xn_d;
  logic ab_d;
  logic x_d;
  logic ra_d;
  logic xn_s;
  logic ab_s;
  logic x_s;

  // T5A hookup: S1n=sela, S2=sela_n, S3n=sela_n, S4=sela, S5n=selb, S6=selb_n.
  always_comb begin
    ga_s = (a1 & ~sela & sela_n) | (a2 & ~sela_n & sela);
    gb_s = (b1 & ~sela & sela_n) | (b2 & ~sela_n & sela);
    xn_d = ~((ga_s & ~selb & selb_n) | (gb_s & selb & ~selb_n));
  end

  // Inverter after T5A, then D24 with A1=c, A2=selc, B1=ab, B2=selc_n,
  // then the final inverter.
  always_comb begin
    ab_d = ~xn_s;
    x_d  = ~((c & selc) | (ab_s & selc_n));
    ra_d = ~x_s;
  end

`ifdef K052109_CELL_DELAY_EN
  // Transport-delay each cell output so that every edge propagates.
  always @(xn_d) xn_s <= #(T5A_DLY_NS) xn_d;
  // Transport delay of the first inverter.
  always @(ab_d) ab_s <= #(INV1_DLY_NS) ab_d;
  // Transport delay of the D24 cell.
  always @(x_d) x_s <= #(D24_DLY_NS) x_d;
  // Transport delay of the final inverter.
  always @(ra_d) ra <= #(INV2_DLY_NS) ra_d;
`else
  assign xn_s = xn_d;
  assign ab_s = ab_d;
  assign x_s  = x_d;
  assign ra   = ra_d;
`endif

endmodule : k052109_sel_bit

// File: rtl/k052109_addr_sel_slice.sv
// WIDTH-bit address-select slice of the 052109 tilemap chip. Each bit is an
// independent k052109_sel_bit; ra is the combinational result and ra_q is
// the same value after one register stage for the RAM address bus.
// Optional build macro: K052109_CELL_DELAY_EN (simulation cell delays).
`timescale 1ns/1ps
module k052109_addr_sel_slice
  import k052109_pkg::*;
#(
  parameter int unsigned WIDTH = K052109_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] a2,
  input  logic [WIDTH-1:0] b1,
  input  logic [WIDTH-1:0] b2,
  input  logic [WIDTH-1:0] c,
  input  logic             sela,
  input  logic             sela_n,
  input  logic             selb,
  input  logic             selb_n,
  input  logic             selc,
  input  logic             selc_n,
  output logic [WIDTH-1:0] ra,
  output logic [WIDTH-1:0] ra_q
);

  logic [WIDTH-1:0] ra_d;

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
    k052109_sel_bit u_bit (
      .a1     (a1[i]),
      .a2     (a2[i]),
      .b1     (b1[i]),
      .b2     (b2[i]),
      .c      (c[i]),
      .sela   (sela),
      .sela_n (sela_n),
      .selb   (selb),
      .selb_n (selb_n),
      .selc   (selc),
      .selc_n (selc_n),
      .ra     (ra[i])
    );
  end

  // Next register value: always the current combinational address.
  always_comb begin
    ra_d = ra;
  end

  // Output register; reset clears it at once, release loads on next edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ra_q <= {WIDTH{1'b0}};
    end else begin
      ra_q <= ra_d;
    end
  end

endmodule : k052109_addr_sel_slice

// File: tb/tb_k052109_addr_sel_slice.sv
// Self-checking bench for k052109_addr_sel_slice: directed select tables,
// non-complementary selects, pipeline, async reset, randomized vectors
// against a behavioural model, and an exhaustive 1-bit sweep.
`timescale 1ns/1ps
module tb_k052109_addr_sel_slice;

  logic       clk;
  logic       reset;
  logic [7:0] a1, a2, b1, b2, c;
  logic       sela, sela_n, selb, selb_n, selc, selc_n;
  logic [7:0] ra, ra_q;

  // single-bit instance for the exhaustive sweep
  logic       s_a1, s_a2, s_b1, s_b2, s_c;
  logic       s_sela, s_sela_n, s_selb, s_selb_n, s_selc, s_selc_n;
  logic [0:0] s_ra, s_ra_q;

  int checks = 0;
  int errors = 0;

  k052109_addr_sel_slice #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .a1(a1), .a2(a2), .b1(b1), .b2(b2), .c(c),
    .sela(sela), .sela_n(sela_n), .selb(selb), .selb_n(selb_n),
    .selc(selc), .selc_n(selc_n), .ra(ra), .ra_q(ra_q)
  );

  k052109_addr_sel_slice #(.WIDTH(1)) dut1 (
    .clk(clk), .reset(reset), .a1(s_a1), .a2(s_a2), .b1(s_b1), .b2(s_b2),
    .c(s_c), .sela(s_sela), .sela_n(s_sela_n), .selb(s_selb),
    .selb_n(s_selb_n), .selc(s_selc), .selc_n(s_selc_n),
    .ra(s_ra), .ra_q(s_ra_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: OR of each source enabled by its select-pair conditions, then
  // override with c gated by selc and the selection gated by selc_n.
  function automatic logic [7:0] model_ra(
    input logic [7:0] m_a1, m_a2, m_b1, m_b2, m_c,
    input logic m_sa, m_san, m_sb, m_sbn, m_sc, m_scn);
    logic first, second, grp_a, grp_b;
    logic [7:0] ab;
    first  = ~m_sa & m_san;
    second = m_sa & ~m_san;
    grp_a  = ~m_sb & m_sbn;
    grp_b  = m_sb & ~m_sbn;
    ab = 8'h00;
    if (first  && grp_a) ab = ab | m_a1;
    if (second && grp_a) ab = ab | m_a2;
    if (first  && grp_b) ab = ab | m_b1;
    if (second && grp_b) ab = ab | m_b2;
    return (m_sc ? m_c : 8'h00) | (m_scn ? ab : 8'h00);
  endfunction

  task automatic set_sel(input logic sa, input logic sb, input logic sc);
    sela = sa; sela_n = ~sa;
    selb = sb; selb_n = ~sb;
    selc = sc; selc_n = ~sc;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    checks++;
    if (ra_q !== 8'h00) begin
      errors++;
      $display("FAIL reset_ra_q got %h want 00", ra_q);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_select_table();
    logic [7:0] exp_tbl [8];
    exp_tbl[0] = 8'h11; exp_tbl[1] = 8'h22; exp_tbl[2] = 8'h44; exp_tbl[3] = 8'h88;
    exp_tbl[4] = 8'hF0; exp_tbl[5] = 8'hF0; exp_tbl[6] = 8'hF0; exp_tbl[7] = 8'hF0;
    a1 = 8'h11; a2 = 8'h22; b1 = 8'h44; b2 = 8'h88; c = 8'hF0;
    for (int i = 0; i < 8; i++) begin
      set_sel(i[0], i[1], i[2]);
      #1;
      checks++;
      if (ra !== exp_tbl[i]) begin
        errors++;
        $display("FAIL sel_table idx=%0d got %h want %h", i, ra, exp_tbl[i]);
      end
    end
  endtask

  task automatic test_noncomp();
    a1 = 8'h11; a2 = 8'h22; b1 = 8'h44; b2 = 8'h88; c = 8'hF0;
    set_sel(1'b0, 1'b0, 1'b0);
    sela_n = 1'b0;
    #1;
    checks++;
    if (ra !== 8'h00) begin
      errors++;
      $display("FAIL noncomp_sela got %h want 00", ra);
    end
    a1 = 8'hF0; c = 8'h0F;
    set_sel(1'b0, 1'b0, 1'b1);
    selc_n = 1'b1;
    #1;
    checks++;
    if (ra !== 8'hFF) begin
      errors++;
      $display("FAIL noncomp_selc_11 got %h want FF", ra);
    end
    selc = 1'b0; selc_n = 1'b0;
    #1;
    checks++;
    if (ra !== 8'h00) begin
      errors++;
      $display("FAIL noncomp_selc_00 got %h want 00", ra);
    end
  endtask

  task automatic test_pipeline();
    @(negedge clk);
    a1 = 8'h11; a2 = 8'h22; b1 = 8'h44; b2 = 8'h88; c = 8'hF0;
    set_sel(1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (ra_q !== 8'h11) begin
      errors++;
      $display("FAIL pipe_edge_n got %h want 11", ra_q);
    end
    set_sel(1'b1, 1'b0, 1'b0);
    #1;
    checks++;
    if (ra_q !== 8'h11 || ra !== 8'h22) begin
      errors++;
      $display("FAIL pipe_between got ra_q=%h ra=%h want 11/22", ra_q, ra);
    end
    @(posedge clk); #1;
    checks++;
    if (ra_q !== 8'h22) begin
      errors++;
      $display("FAIL pipe_edge_n1 got %h want 22", ra_q);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    a1 = 8'hAA;
    set_sel(1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (ra_q !== 8'hAA) begin
      errors++;
      $display("FAIL areset_preload got %h want AA", ra_q);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (ra_q !== 8'h00) begin
      errors++;
      $display("FAIL areset_immediate got %h want 00", ra_q);
    end
    a1 = 8'h55;
    #1;
    checks++;
    if (ra !== 8'h55) begin
      errors++;
      $display("FAIL areset_ra_tracks got %h want 55", ra);
    end
    @(posedge clk); #1;
    checks++;
    if (ra_q !== 8'h00) begin
      errors++;
      $display("FAIL areset_held got %h want 00", ra_q);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (ra_q !== 8'h00) begin
      errors++;
      $display("FAIL areset_release_wait got %h want 00", ra_q);
    end
    @(posedge clk); #1;
    checks++;
    if (ra_q !== 8'h55) begin
      errors++;
      $display("FAIL areset_first_load got %h want 55", ra_q);
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_v;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      a1 = 8'($urandom); a2 = 8'($urandom); b1 = 8'($urandom);
      b2 = 8'($urandom); c  = 8'($urandom);
      {sela, sela_n, selb, selb_n, selc, selc_n} = 6'($urandom);
      exp_v = model_ra(a1, a2, b1, b2, c, sela, sela_n, selb, selb_n, selc, selc_n);
      #1;
      checks++;
      if (ra !== exp_v) begin
        errors++;
        $display("FAIL rand_ra n=%0d got %h want %h", n, ra, exp_v);
      end
      @(posedge clk); #1;
      checks++;
      if (ra_q !== exp_v) begin
        errors++;
        $display("FAIL rand_ra_q n=%0d got %h want %h", n, ra_q, exp_v);
      end
    end
  endtask

  task automatic test_exhaustive_bit();
    logic [10:0] v;
    logic ga, gb, xn, ab, exp_b;
    for (int i = 0; i < 2048; i++) begin
      v = 11'(i);
      {s_a1, s_a2, s_b1, s_b2, s_c, s_sela, s_sela_n,
       s_selb, s_selb_n, s_selc, s_selc_n} = v;
      ga = (s_a1 & ~s_sela & s_sela_n) | (s_a2 & ~s_sela_n & s_sela);
      gb = (s_b1 & ~s_sela & s_sela_n) | (s_b2 & ~s_sela_n & s_sela);
      xn = ~((ga & ~s_selb & s_selb_n) | (gb & s_selb & ~s_selb_n));
      ab = ~xn;
      exp_b = ~(~((s_c & s_selc) | (ab & s_selc_n)));
      #1;
      checks++;
      if (s_ra[0] !== exp_b) begin
        errors++;
        $display("FAIL exhaustive_bit v=%b got %b want %b", v, s_ra[0], exp_b);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    a1 = 8'h00; a2 = 8'h00; b1 = 8'h00; b2 = 8'h00; c = 8'h00;
    set_sel(1'b0, 1'b0, 1'b0);
    {s_a1, s_a2, s_b1, s_b2, s_c} = 5'b00000;
    {s_sela, s_sela_n, s_selb, s_selb_n, s_selc, s_selc_n} = 6'b010101;
    test_reset();
    test_select_table();
    test_noncomp();
    test_pipeline();
    test_async_reset();
    test_random();
    test_exhaustive_bit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_k052109_addr_sel_slice
